// File: rtl/acct_cfg_loader_if.sv
// rtl/acct_cfg_loader_if.sv - REG_BUS register access interface
// The initiator drives the request fields; the target answers with rdata/ready/error.
interface REG_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    write;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    valid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    error;
  logic                    ready;

  modport in  (input  addr, write, wdata, wstrb, valid, output rdata, error, ready);
  modport out (output addr, write, wdata, wstrb, valid, input  rdata, error, ready);
endinterface

// File: rtl/acct_cfg_loader.sv
// rtl/acct_cfg_loader.sv - REG_BUS initiator that writes and optionally verifies the access-control config table
// A started sequence writes every snapshot word, reads them back when VERIFY=1, and reports the first failure.
module acct_cfg_loader #(
  parameter int unsigned  NB_WORDS  = 9,
  parameter logic [31:0]  BASE_ADDR = 32'h0,
  parameter bit           VERIFY    = 1'b1,
  parameter int unsigned  TIMEOUT   = 255,
  localparam int unsigned IDX_W     = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [NB_WORDS-1:0][31:0] cfg_data_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [1:0]               err_code_o,
  output logic [IDX_W-1:0]         err_idx_o,
  REG_BUS.out                      reg_o
);

  localparam logic [1:0]       ERR_NONE    = 2'd0;
  localparam logic [1:0]       ERR_BUS     = 2'd1;
  localparam logic [1:0]       ERR_TIMEOUT = 2'd2;
  localparam logic [1:0]       ERR_VERIFY  = 2'd3;
  localparam logic [IDX_W-1:0] LAST_K      = IDX_W'(NB_WORDS - 1);
  localparam logic [15:0]      WAIT_LAST   = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_DONE
  } state_t;

  state_t                     state;
  logic [NB_WORDS-1:0][31:0]  snap;
  logic [IDX_W-1:0]           k;
  logic [15:0]                wait_cnt;
  logic                       valid_q;
  logic                       write_q;
  logic [31:0]                addr_q;
  logic [31:0]                wdata_q;
  logic                       active;
  logic                       last_word;
  logic [1:0]                 fail_code;

  function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + (32'(idx) << 2);
  endfunction

  assign active    = (state == ST_WR) || (state == ST_RD);
  assign last_word = (k == LAST_K);

  // Bus error outranks a read-back mismatch; a stalled word times out on its last allowed wait cycle.
  always_comb begin
    fail_code = ERR_NONE;
    if (active) begin
      if (reg_o.ready) begin
        if (reg_o.error) begin
          fail_code = ERR_BUS;
        end else if ((state == ST_RD) && (reg_o.rdata != snap[k])) begin
          fail_code = ERR_VERIFY;
        end
      end else if (wait_cnt == WAIT_LAST) begin
        fail_code = ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      snap       <= '0;
      k          <= '0;
      wait_cnt   <= '0;
      valid_q    <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= ERR_NONE;
      err_idx_o  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state      <= ST_WR;
            snap       <= cfg_data_i;
            k          <= '0;
            wait_cnt   <= '0;
            valid_q    <= 1'b1;
            write_q    <= 1'b1;
            addr_q     <= word_addr('0);
            wdata_q    <= cfg_data_i[0];
            busy_o     <= 1'b1;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
            err_idx_o  <= '0;
          end
        end

        ST_WR, ST_RD: begin
          if (fail_code != ERR_NONE) begin
            state      <= ST_DONE;
            valid_q    <= 1'b0;
            write_q    <= 1'b0;
            wait_cnt   <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            err_o      <= 1'b1;
            err_code_o <= fail_code;
            err_idx_o  <= k;
          end else if (reg_o.ready) begin
            wait_cnt <= '0;
            if (!last_word) begin
              k      <= k + 1'b1;
              addr_q <= word_addr(k + 1'b1);
              if (state == ST_WR) begin
                wdata_q <= snap[k + 1'b1];
              end
            end else if ((state == ST_WR) && VERIFY) begin
              state   <= ST_RD;
              k       <= '0;
              write_q <= 1'b0;
              addr_q  <= word_addr('0);
              wdata_q <= '0;
            end else begin
              state   <= ST_DONE;
              k       <= '0;
              valid_q <= 1'b0;
              write_q <= 1'b0;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign reg_o.valid = valid_q;
  assign reg_o.write = write_q;
  assign reg_o.addr  = addr_q;
  assign reg_o.wdata = wdata_q;
  assign reg_o.wstrb = 4'hF;

endmodule

// File: tb/tb_acct_cfg_loader.sv
// tb/tb_acct_cfg_loader.sv - scoreboard bench for acct_cfg_loader with a randomized REG_BUS responder
// Stimulus pushes predicted transfers/results; a negedge monitor pops and compares them.
module tb_acct_cfg_loader;

  localparam int          NB   = 9;
  localparam int          NT   = 2 * NB;
  localparam int          TMO  = 5;
  localparam logic [31:0] BASE = 32'h0;
  localparam bit          VER  = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    logic [1:0] code;
    logic [3:0] idx;
    int         rel;
  } res_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [NB-1:0][31:0] cfg = '0;
  logic [NB-1:0][31:0] cfg_ref = '0;
  logic                busy, done, err;
  logic [1:0]          code;
  logic [3:0]          idx;

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   stall [NT];
  int   err_t = -1;
  int   bad_t = -1;
  txn_t exp_txn [$];
  res_t exp_res [$];

  REG_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  acct_cfg_loader #(
    .NB_WORDS (NB),
    .BASE_ADDR(BASE),
    .VERIFY   (VER),
    .TIMEOUT  (TMO)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .cfg_data_i(cfg),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err),
    .err_code_o(code),
    .err_idx_o (idx),
    .reg_o     (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic void chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
  endfunction

  // Reference: walk the transfer list word by word and stop at the first failing transfer.
  task automatic predict();
    int s = 0;
    logic [1:0] c = 2'd0;
    logic [3:0] ix = 4'd0;
    for (int t = 0; t < NT; t++) begin
      int  w  = t % NB;
      bit  wr = (t < NB);
      if (!wr && !VER) break;
      if (stall[t] >= TMO) begin
        s += TMO; c = 2'd2; ix = 4'(w);
        break;
      end
      s += stall[t] + 1;
      exp_txn.push_back('{addr: BASE + 32'(4 * w), write: wr, wdata: wr ? cfg_ref[w] : 32'h0});
      if (t == err_t) begin
        c = 2'd1; ix = 4'(w);
        break;
      end
      if (!wr && t == bad_t) begin
        c = 2'd3; ix = 4'(w);
        break;
      end
    end
    exp_res.push_back('{code: c, idx: ix, rel: s + 1});
  endtask

  // Responder: ready after stall[t] wait cycles, error/corrupted read on the planned transfer.
  initial begin
    int          t = 0;
    int          waited = 0;
    bit          hs = 1'b0;
    logic [31:0] mem [16];
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    bus.ready = 1'b0;
    bus.error = 1'b0;
    bus.rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || (!bus.valid && !busy)) begin
        t = 0; waited = 0; hs = 1'b0;
        bus.ready = 1'b0; bus.error = 1'b0;
      end else begin
        if (hs) begin
          t++; waited = 0;
        end
        hs = 1'b0;
        bus.ready = 1'b0;
        bus.error = 1'b0;
        if (bus.valid && t < NT) begin
          if (waited < stall[t]) begin
            waited++;
          end else begin
            bus.ready = 1'b1;
            bus.error = (t == err_t);
            hs = 1'b1;
            if (bus.write) mem[bus.addr[5:2]] = bus.wdata;
            else bus.rdata = (t == bad_t) ? 32'h0 : mem[bus.addr[5:2]];
          end
        end
      end
    end
  end

  // Monitor: compares every completed transfer and every done pulse against the scoreboard.
  initial begin
    txn_t        e;
    res_t        r;
    logic [31:0] pa = 32'h0, pw = 32'h0;
    logic        pwr = 1'b0;
    bit          pstall = 1'b0, pdone = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pstall = 1'b0; pdone = 1'b0;
      end else begin
        if (pdone) chk(!done, "done_one_cycle", 32'(done), 32'h0);
        if (bus.valid) begin
          chk(busy, "busy_during_xfer", 32'(busy), 32'h1);
          if (pstall) chk(bus.addr == pa && bus.wdata == pw && bus.write == pwr, "stall_stable", bus.addr, pa);
          if (bus.ready) begin
            chk(exp_txn.size() != 0, "txn_expected", 32'(exp_txn.size()), 32'h1);
            if (exp_txn.size() != 0) begin
              e = exp_txn.pop_front();
              chk(bus.addr == e.addr, "txn_addr", bus.addr, e.addr);
              chk(bus.write == e.write, "txn_write", 32'(bus.write), 32'(e.write));
              chk(bus.wstrb == 4'hF, "txn_wstrb", 32'(bus.wstrb), 32'hF);
              if (e.write) chk(bus.wdata == e.wdata, "txn_wdata", bus.wdata, e.wdata);
            end
          end
          pstall = !bus.ready;
          pa = bus.addr; pw = bus.wdata; pwr = bus.write;
        end else begin
          pstall = 1'b0;
        end
        if (done) begin
          chk(exp_res.size() != 0, "done_expected", 32'(exp_res.size()), 32'h1);
          if (exp_res.size() != 0) begin
            r = exp_res.pop_front();
            chk(code == r.code, "err_code", 32'(code), 32'(r.code));
            chk(idx == r.idx, "err_idx", 32'(idx), 32'(r.idx));
            chk(err == (r.code != 2'd0), "err_flag", 32'(err), 32'(r.code != 2'd0));
            chk(cyc - start_cyc == r.rel, "done_cycle", 32'(cyc - start_cyc), 32'(r.rel));
            chk(!busy && !bus.valid, "done_idle_bus", {busy, bus.valid}, 32'h0);
          end
        end
        pdone = done;
      end
    end
  end

  task automatic clean_plan();
    for (int t = 0; t < NT; t++) stall[t] = 0;
    err_t = -1;
    bad_t = -1;
  endtask

  task automatic t1_cfg();
    for (int i = 0; i < NB; i++) cfg[i] = 32'(i) * 32'h11111111;
  endtask

  task automatic run_seq();
    bit got = 1'b0;
    @(negedge clk);
    cfg_ref = cfg;
    predict();
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk(busy && !err && code == 2'd0, "fresh_start", {busy, err, code}, 32'h8);
    for (int i = 0; i < NB; i++) cfg[i] = $urandom;
    for (int n = 0; n < 400 && !got; n++) begin
      start = (n == 1 && busy);
      @(negedge clk);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk(got, "done_within_bound", 32'(got), 32'h1);
  endtask

  initial begin
    clean_plan();
    repeat (3) @(negedge clk);
    chk(!bus.valid, "rst_valid", 32'(bus.valid), 32'h0);
    chk(!bus.write, "rst_write", 32'(bus.write), 32'h0);
    chk(bus.addr == 32'h0, "rst_addr", bus.addr, 32'h0);
    chk(bus.wdata == 32'h0, "rst_wdata", bus.wdata, 32'h0);
    chk(bus.wstrb == 4'hF, "rst_wstrb", 32'(bus.wstrb), 32'hF);
    chk(!busy, "rst_busy", 32'(busy), 32'h0);
    chk(!done, "rst_done", 32'(done), 32'h0);
    chk(!err, "rst_err", 32'(err), 32'h0);
    chk(code == 2'd0, "rst_code", 32'(code), 32'h0);
    chk(idx == 4'd0, "rst_idx", 32'(idx), 32'h0);
    rst_n = 1'b1;

    t1_cfg(); run_seq();
    t1_cfg(); for (int t = 0; t < NT; t++) stall[t] = 3; run_seq();
    t1_cfg(); clean_plan(); bad_t = NB + 4; run_seq();
    t1_cfg(); clean_plan(); err_t = 2; run_seq();
    t1_cfg(); clean_plan(); stall[0] = 100; run_seq();
    t1_cfg(); clean_plan(); run_seq();

    // Reset in the middle of the write pass.
    @(negedge clk);
    cfg_ref = cfg;
    predict();
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk(!bus.valid, "midrst_valid", 32'(bus.valid), 32'h0);
    chk(!busy, "midrst_busy", 32'(busy), 32'h0);
    exp_txn.delete();
    exp_res.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t1_cfg(); run_seq();

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NB; i++) cfg[i] = $urandom;
      for (int t = 0; t < NT; t++) begin
        int p = int'($urandom_range(0, 99));
        stall[t] = (p < 70) ? 0 : (p < 98) ? int'($urandom_range(1, TMO - 1)) : int'($urandom_range(TMO, TMO + 3));
      end
      err_t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NT - 1)) : -1;
      bad_t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(NB, NT - 1)) : -1;
      if (bad_t >= 0) cfg[bad_t - NB] = cfg[bad_t - NB] | 32'h1;
      run_seq();
    end

    repeat (2) @(negedge clk);
    chk(exp_txn.size() == 0, "txn_queue_drained", 32'(exp_txn.size()), 32'h0);
    chk(exp_res.size() == 0, "res_queue_drained", 32'(exp_res.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "simulation did not finish");
  end

endmodule
